// File: rtl/instruction_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage_if
// Brief    : Instruction-memory request/response bundle between fetch and imem.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_stage_if;
    logic        imemReq;
    logic [63:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic        imemRvalid;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemRdata,
        input  imemRvalid
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemRdata,
        output imemRvalid
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Brief    : RV64 IF stage: PC, next-PC select, imem handshake, IF/ID register.
// Revision : 1.0
// ============================================================================
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] TRAP_PC  = 64'h100,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic [1:0]                  pcSel,
    input  wire logic [63:0]                 branchTarget,
    input  wire logic [63:0]                 jalrTarget,
    input  wire logic                        pcStall,
    input  wire logic                        ifidStall,
    instruction_fetch_stage_if.master        imem,
    output logic [63:0]                      pc,
    output logic [31:0]                      inst,
    output logic [63:0]                      idPc,
    output logic [63:0]                      idPcPlus4,
    output logic                             idValid,
    output logic                             idFault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HELD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [63:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        id_fault_q, id_fault_d;

    logic        stall;
    logic        redirect;
    logic        misaligned;
    logic [63:0] pc_plus4;
    logic [63:0] target;
    logic        deliver;
    logic        fault_load;
    logic [31:0] deliver_data;

    assign stall      = pcStall | ifidStall;
    assign redirect   = (pcSel != 2'd0) & ~stall;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign pc_plus4   = pc_q + 64'd4;

    always_comb begin
        target = pc_plus4;
        case (pcSel)
            2'd1:    target = branchTarget;
            2'd2:    target = jalrTarget & ~64'd1;
            2'd3:    target = TRAP_PC;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        inst_d        = inst_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        id_fault_d    = id_fault_q;
        deliver       = 1'b0;
        fault_load    = 1'b0;
        deliver_data  = imem.imemRdata;

        if (redirect) begin
            pc_d = target;
        end

        case (state_q)
            S_REQ: begin
                // A misaligned PC never reaches memory; it parks here as a fault until redirected.
                if (misaligned) begin
                    fault_load = ~redirect;
                end else if (imem.imemReady) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imemRvalid) begin
                    if (redirect) begin
                        state_d = S_REQ;
                    end else if (stall) begin
                        skid_d  = imem.imemRdata;
                        state_d = S_HELD;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_HELD: begin
                if (!stall) begin
                    state_d = S_REQ;
                    if (!redirect) begin
                        deliver      = 1'b1;
                        deliver_data = skid_q;
                    end
                end
            end
            S_DRAIN: begin
                if (imem.imemRvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (deliver) begin
            pc_d = pc_plus4;
        end

        if (!ifidStall) begin
            if (deliver) begin
                inst_d        = deliver_data;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
                id_fault_d    = 1'b0;
            end else if (fault_load) begin
                inst_d        = NOP_INST;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b0;
                id_fault_d    = 1'b1;
            end else begin
                inst_d        = NOP_INST;
                id_valid_d    = 1'b0;
                id_fault_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            skid_q        <= 32'd0;
            inst_q        <= NOP_INST;
            id_pc_q       <= 64'd0;
            id_pc_plus4_q <= 64'd0;
            id_valid_q    <= 1'b0;
            id_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_q        <= skid_d;
            inst_q        <= inst_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            id_fault_q    <= id_fault_d;
        end
    end

    assign imem.imemReq  = (state_q == S_REQ) & ~misaligned & ~rst;
    assign imem.imemAddr = pc_q;

    assign pc        = pc_q;
    assign inst      = inst_q;
    assign idPc      = id_pc_q;
    assign idPcPlus4 = id_pc_plus4_q;
    assign idValid   = id_valid_q;
    assign idFault   = id_fault_q;

endmodule
`default_nettype wire
